// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- parametrised three-stage floating-point multiplier, RNE rounding.
//
// Stage 1 unpacks and classifies the operands and forms the biased exponent sum.
// Stage 2 forms the full significand product. Stage 3 normalises, rounds, packs
// the result and derives the exception flags. A result appears three cycles
// after its operands are accepted. Every stage advances together whenever the
// output is empty or taken downstream, and holds otherwise.
//
// Build option: define FP_MUL_DENORM_EN to support subnormal operands and results.
// Without it, zero-exponent operands read as signed zero and tiny results flush
// to signed zero with underflow and inexact raised.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_a, i_b     operands {sign, exponent, fraction}
//   i_vld        operands valid
//   o_rdy        operands are accepted this cycle when i_vld is high
//   o_res        product
//   o_res_vld    o_res and the flags are valid
//   i_rdy        downstream takes the result
//   o_overflow   finite result rounded past the largest finite value -> Inf
//   o_underflow  tiny and inexact result
//   o_invalid    NaN operand or Inf * 0
//   o_inexact    rounding discarded non-zero bits
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TOT_W = 1 + EXP_W + MAN_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [TOT_W-1:0] i_a,
  input  logic [TOT_W-1:0] i_b,
  input  logic             i_vld,
  output logic             o_rdy,
  output logic [TOT_W-1:0] o_res,
  output logic             o_res_vld,
  input  logic             i_rdy,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic             o_invalid,
  output logic             o_inexact
);

  localparam int SIG_W = MAN_W + 1;            // significand incl. hidden bit
  localparam int PW    = 2 * SIG_W;            // full product width
  localparam int E_W   = EXP_W + 2;            // signed exponent sum
  localparam int LZ_W  = $clog2(PW + 1);
  localparam int EN_W  = EXP_W + LZ_W + 2;     // exponent after normalisation

  localparam logic signed [E_W-1:0]  BIAS     = E_W'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EN_W-1:0] EMAX     = EN_W'((2 ** EXP_W) - 1);
  localparam logic signed [EN_W-1:0] ONE      = EN_W'(1);
  localparam logic [EXP_W-1:0]       EXP_ONES = '1;

  typedef struct packed {
    logic             sign;
    logic             nan;
    logic             inf;
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } op_t;

  function automatic op_t unpack(input logic [TOT_W-1:0] v);
    op_t              o;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e      = v[TOT_W-2 -: EXP_W];
    f      = v[MAN_W-1:0];
    o.sign = v[TOT_W-1];
    o.nan  = (e == EXP_ONES) && (f != '0);
    o.inf  = (e == EXP_ONES) && (f == '0);
`ifdef FP_MUL_DENORM_EN
    // Subnormals carry a zero hidden bit and sit at the minimum exponent.
    o.zero = (e == '0) && (f == '0);
    o.exp  = (e == '0) ? EXP_W'(1) : e;
    o.sig  = {(e != '0), f};
`else
    o.zero = (e == '0);
    o.exp  = e;
    o.sig  = {1'b1, f};
`endif
    return o;
  endfunction

  // Leading-zero count; an all-zero vector reports PW.
  function automatic logic [LZ_W-1:0] lzc(input logic [PW-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(PW);
    for (int i = 0; i < PW; i++)
      if (v[i]) n = LZ_W'(PW - 1 - i);
    return n;
  endfunction

  // Round-to-nearest-even increment decision.
  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  // Right shift returning {shifted value, OR of every bit shifted out}.
  function automatic logic [PW:0] shr_sticky(input logic [PW-1:0] v, input logic [LZ_W-1:0] sh);
    logic [PW-1:0] mask;
    mask = ~({PW{1'b1}} << sh);
    return {v >> sh, |(v & mask)};
  endfunction

  logic adv;
  assign adv   = !o_res_vld | i_rdy;
  assign o_rdy = adv;

  // ---- Stage 1: unpack, classify, exponent sum ----
  op_t                   op_a, op_b;
  logic signed [E_W-1:0] e_sum;
  logic                  nan_in, inf_in, zero_in;

  assign op_a    = unpack(i_a);
  assign op_b    = unpack(i_b);
  assign e_sum   = signed'(E_W'(op_a.exp)) + signed'(E_W'(op_b.exp)) - BIAS;
  assign nan_in  = op_a.nan | op_b.nan | (op_a.inf & op_b.zero) | (op_b.inf & op_a.zero);
  assign inf_in  = op_a.inf | op_b.inf;
  assign zero_in = op_a.zero | op_b.zero;

  logic                  vld_p0, sign_p0, nan_p0, inf_p0, zero_p0;
  logic signed [E_W-1:0] e_p0;
  logic [SIG_W-1:0]      sig_a_p0, sig_b_p0;

  // ---- Stage 2: significand product ----
  logic                  vld_p1, sign_p1, nan_p1, inf_p1, zero_p1;
  logic signed [E_W-1:0] e_p1;
  logic [PW-1:0]         prod_p1;

  always_ff @(posedge i_clk) begin
    if (adv) begin
      sign_p0  <= op_a.sign ^ op_b.sign;
      nan_p0   <= nan_in;
      inf_p0   <= inf_in;
      zero_p0  <= zero_in;
      e_p0     <= e_sum;
      sig_a_p0 <= op_a.sig;
      sig_b_p0 <= op_b.sig;
      sign_p1  <= sign_p0;
      nan_p1   <= nan_p0;
      inf_p1   <= inf_p0;
      zero_p1  <= zero_p0;
      e_p1     <= e_p0;
      prod_p1  <= PW'(sig_a_p0) * PW'(sig_b_p0);
    end
  end

  // ---- Stage 3: normalise, round, pack, flags ----
  logic [LZ_W-1:0]        lz;
  logic [PW-1:0]          norm, rnd_in;
  logic signed [EN_W-1:0] e_n, e_f;
  logic                   tiny, lost, guard, sticky, inexact, carry;
  logic [SIG_W-1:0]       sig;
  logic [SIG_W:0]         sig_r;
  logic [TOT_W-1:0]       res_s3;
  logic                   ov_s3, un_s3, inv_s3, inx_s3;
`ifdef FP_MUL_DENORM_EN
  logic signed [EN_W-1:0] sh;
  logic [LZ_W-1:0]        sh_amt;
`endif

  always_comb begin
    // Put the leading one at the top; the top bit is worth 2, hence the +1.
    lz     = lzc(prod_p1);
    norm   = prod_p1 << lz;
    e_n    = EN_W'(e_p1) + ONE - signed'(EN_W'(lz));
    tiny   = e_n < ONE;
    rnd_in = norm;
    lost   = 1'b0;
`ifdef FP_MUL_DENORM_EN
    sh     = '0;
    sh_amt = '0;
    if (tiny) begin
      // Denormalise down to the minimum exponent, keeping shifted-out bits as sticky.
      sh     = ONE - e_n;
      sh_amt = (sh > EN_W'(PW)) ? LZ_W'(PW) : LZ_W'(sh);
      {rnd_in, lost} = shr_sticky(norm, sh_amt);
    end
`endif
    sig     = rnd_in[PW-1 -: SIG_W];
    guard   = rnd_in[MAN_W];
    sticky  = (|rnd_in[MAN_W-1:0]) | lost;
    inexact = guard | sticky;
    sig_r   = {1'b0, sig} + (SIG_W + 1)'(rne_up(sig[0], guard, sticky));
    // Rounding carry-out leaves 10.00..0: bump the exponent, fraction is already zero.
    carry   = (sig_r[SIG_W -: 2] == 2'b10);
    e_f     = carry ? e_n + ONE : e_n;

    res_s3 = '0;
    ov_s3  = 1'b0;
    un_s3  = 1'b0;
    inv_s3 = 1'b0;
    inx_s3 = 1'b0;
    if (nan_p1) begin
      res_s3 = {1'b0, EXP_ONES, 1'b1, (MAN_W - 1)'(0)};
      inv_s3 = 1'b1;
    end else if (inf_p1) begin
      res_s3 = {sign_p1, EXP_ONES, MAN_W'(0)};
    end else if (zero_p1) begin
      res_s3 = {sign_p1, (TOT_W - 1)'(0)};
    end else if (tiny) begin
`ifdef FP_MUL_DENORM_EN
      // A round-up into the hidden position lands on the smallest normal.
      res_s3 = {sign_p1, (EXP_W - 1)'(0), sig_r[MAN_W], sig_r[MAN_W-1:0]};
      un_s3  = inexact;
      inx_s3 = inexact;
`else
      res_s3 = {sign_p1, (TOT_W - 1)'(0)};
      un_s3  = 1'b1;
      inx_s3 = 1'b1;
`endif
    end else if (e_f >= EMAX) begin
      res_s3 = {sign_p1, EXP_ONES, MAN_W'(0)};
      ov_s3  = 1'b1;
      inx_s3 = 1'b1;
    end else begin
      res_s3 = {sign_p1, e_f[EXP_W-1:0], sig_r[MAN_W-1:0]};
      inx_s3 = inexact;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      o_res_vld   <= 1'b0;
      o_res       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_invalid   <= 1'b0;
      o_inexact   <= 1'b0;
    end else if (adv) begin
      vld_p0      <= i_vld;
      vld_p1      <= vld_p0;
      o_res_vld   <= vld_p1;
      o_res       <= vld_p1 ? res_s3 : '0;
      o_overflow  <= vld_p1 & ov_s3;
      o_underflow <= vld_p1 & un_s3;
      o_invalid   <= vld_p1 & inv_s3;
      o_inexact   <= vld_p1 & inx_s3;
    end
  end

endmodule
